// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: compare op encodings,
// the flush FSM state type and reserved-op detection.
package branch_resolve_unit_pkg;

   localparam logic [2:0] OP_BEQ  = 3'b000;
   localparam logic [2:0] OP_BNE  = 3'b001;
   localparam logic [2:0] OP_BLT  = 3'b010;
   localparam logic [2:0] OP_BGE  = 3'b011;
   localparam logic [2:0] OP_BLTU = 3'b100;
   localparam logic [2:0] OP_BGEU = 3'b101;

   // Both reserved encodings (110, 111) have the two upper bits set.
   localparam logic [2:0] OP_RSVD_MASK = 3'b110;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   function automatic logic is_reserved_op(input logic [2:0] op);
      return (op & OP_RSVD_MASK) == OP_RSVD_MASK;
   endfunction

endpackage

// File: rtl/branch_compare_core.sv
// Combinational branch condition evaluator for any operand width; also
// usable as the set-less-than path of an ALU.
module branch_compare_core
   import branch_resolve_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_cond
);

   logic [WIDTH:0] w_diff;
   logic           w_eq;
   logic           w_ult;
   logic           w_slt;

   assign w_diff = {1'b0, i_a} - {1'b0, i_b};
   assign w_eq   = (i_a == i_b);
   assign w_ult  = w_diff[WIDTH];
   // Differing signs decide by the sign of A alone, so no overflow case exists.
   assign w_slt  = (i_a[WIDTH-1] != i_b[WIDTH-1]) ? i_a[WIDTH-1] : w_diff[WIDTH-1];

   always_comb begin
      o_cond = 1'b0;
      if (!is_reserved_op(i_op)) begin
         case (i_op)
            OP_BEQ:  o_cond = w_eq;
            OP_BNE:  o_cond = ~w_eq;
            OP_BLT:  o_cond = w_slt;
            OP_BGE:  o_cond = ~w_slt;
            OP_BLTU: o_cond = w_ult;
            OP_BGEU: o_cond = ~w_ult;
            default: o_cond = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves a branch one cycle after acceptance, checks it against the prediction
// and holds flush for FLUSH_CYCLES on a mispredict. Optional counters: BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int PC_WIDTH     = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          op,
   input  logic [WIDTH-1:0]    in_A,
   input  logic [WIDTH-1:0]    in_B,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic [PC_WIDTH-1:0] offset,
   input  logic                pred_taken,
   output logic                out_valid,
   output logic                taken,
   output logic [PC_WIDTH-1:0] target,
   output logic                mispredict,
   output logic                flush
`ifdef BRANCH_RESOLVE_STATS_EN
   ,
   output logic [31:0]         stat_branches,
   output logic [31:0]         stat_mispredicts
`endif
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;

   logic                w_cond;
   logic                w_accept;
   logic                w_mis_nxt;
   logic [PC_WIDTH-1:0] w_target_nxt;

   logic                r_out_valid;
   logic                r_taken;
   logic                r_mispredict;
   logic [PC_WIDTH-1:0] r_target;

   branch_compare_core #(
      .WIDTH (WIDTH)
   ) u_compare (
      .i_op   (op),
      .i_a    (in_A),
      .i_b    (in_B),
      .o_cond (w_cond)
   );

   assign in_ready     = ~reset & (r_state == ST_IDLE);
   assign w_accept     = in_valid & in_ready;
   assign w_mis_nxt    = w_cond ^ pred_taken;
   assign w_target_nxt = pc + PC_WIDTH'(1) + (w_cond ? offset : '0);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && w_mis_nxt) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = CNT_LOAD;
            end
         end
         ST_FLUSH: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // taken/target keep their last values between pulses; mispredict never outlives out_valid.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_out_valid  <= 1'b0;
         r_taken      <= 1'b0;
         r_target     <= '0;
         r_mispredict <= 1'b0;
      end else begin
         r_out_valid  <= w_accept;
         r_mispredict <= w_accept & w_mis_nxt;
         if (w_accept) begin
            r_taken  <= w_cond;
            r_target <= w_target_nxt;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign taken      = r_taken;
   assign target     = r_target;
   assign mispredict = r_mispredict;
   assign flush      = (r_state == ST_FLUSH);

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] r_stat_br;
   logic [31:0] r_stat_mis;

   // Counted on the accepting edge so the totals move together with out_valid.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stat_br  <= '0;
         r_stat_mis <= '0;
      end else begin
         if (w_accept && (r_stat_br != '1)) begin
            r_stat_br <= r_stat_br + 32'd1;
         end
         if (w_accept && w_mis_nxt && (r_stat_mis != '1)) begin
            r_stat_mis <= r_stat_mis + 32'd1;
         end
      end
   end

   assign stat_branches    = r_stat_br;
   assign stat_mispredicts = r_stat_mis;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: 32-bit/2-cycle-flush instance against a behavioural
// model plus a vector table, and an 8-bit/1-cycle-flush instance with hand sequences.
module tb_branch_resolve_unit;

   localparam int FC = 2;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [31:0] in_A, in_B, pc, offset;
   logic        pred_taken;
   logic        out_valid, taken, mispredict, flush;
   logic [31:0] target;

   logic        b_valid, b_ready, b_pred;
   logic [2:0]  b_op;
   logic [7:0]  b_A, b_B;
   logic [15:0] b_pc, b_off, b_target;
   logic        b_out_valid, b_taken, b_mis, b_flush;

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts;
   logic [31:0] b_stat_br, b_stat_mis;
`endif

   branch_resolve_unit #(.WIDTH(32), .PC_WIDTH(32), .FLUSH_CYCLES(FC)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .in_A(in_A), .in_B(in_B), .pc(pc), .offset(offset),
      .pred_taken(pred_taken), .out_valid(out_valid), .taken(taken),
      .target(target), .mispredict(mispredict), .flush(flush)
`ifdef BRANCH_RESOLVE_STATS_EN
      , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
   );

   branch_resolve_unit #(.WIDTH(8), .PC_WIDTH(16), .FLUSH_CYCLES(1)) dut8 (
      .clock(clock), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
      .op(b_op), .in_A(b_A), .in_B(b_B), .pc(b_pc), .offset(b_off),
      .pred_taken(b_pred), .out_valid(b_out_valid), .taken(b_taken),
      .target(b_target), .mispredict(b_mis), .flush(b_flush)
`ifdef BRANCH_RESOLVE_STATS_EN
      , .stat_branches(b_stat_br), .stat_mispredicts(b_stat_mis)
`endif
   );

   int n_checks = 0;
   int n_err    = 0;

   // Behavioural model state: last result and remaining flush cycles.
   logic        m_vld, m_taken, m_mis;
   logic [31:0] m_target;
   int          m_flush_left;
   int unsigned m_br, m_mb;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic ref_taken(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      case (o)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd2:    return $signed(a) <  $signed(b);
         3'd3:    return $signed(a) >= $signed(b);
         3'd4:    return a <  b;
         3'd5:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // One clock for the 32-bit instance; model advanced and every output compared.
   task automatic tick();
      logic        acc, t;
      logic [31:0] tgt;
      acc = in_valid && !reset && (m_flush_left == 0);
      t   = ref_taken(op, in_A, in_B);
      tgt = t ? (pc + 32'd1 + offset) : (pc + 32'd1);
      @(posedge clock);
      #1;
      if (reset) begin
         m_vld = 0; m_taken = 0; m_mis = 0; m_target = '0;
         m_flush_left = 0; m_br = 0; m_mb = 0;
      end else begin
         if (m_flush_left > 0) m_flush_left--;
         m_vld = acc;
         m_mis = acc && (t != pred_taken);
         if (acc) begin
            m_taken  = t;
            m_target = tgt;
            m_br++;
            if (m_mis) begin
               m_mb++;
               m_flush_left = FC;
            end
         end
      end
      chk("out_valid",  out_valid,  m_vld);
      chk("taken",      taken,      m_taken);
      chk("target",     target,     m_target);
      chk("mispredict", mispredict, m_mis);
      chk("flush",      flush,      m_flush_left > 0);
      chk("in_ready",   in_ready,   !reset && (m_flush_left == 0));
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("stat_branches",    stat_branches,    m_br);
      chk("stat_mispredicts", stat_mispredicts, m_mb);
`endif
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, pc, off;
      logic        pred;
      logic        e_taken;
      logic [31:0] e_target;
      logic        e_mis;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset = 1; in_valid = 0; op = 0; in_A = 0; in_B = 0; pc = 0; offset = 0; pred_taken = 0;
      b_valid = 0; b_op = 0; b_A = 0; b_B = 0; b_pc = 0; b_off = 0; b_pred = 0;
      m_vld = 0; m_taken = 0; m_mis = 0; m_target = 0; m_flush_left = 0; m_br = 0; m_mb = 0;

      tbl[0]  = '{3'd2, 32'hFFFFFFFF, 32'h1,        32'h100,      32'h10,       1'b1, 1'b1, 32'h111,      1'b0};
      tbl[1]  = '{3'd2, 32'h80000000, 32'h7FFFFFFF, 32'h200,      32'hFFFFFFFC, 1'b1, 1'b1, 32'h1FD,      1'b0};
      tbl[2]  = '{3'd3, 32'h80000000, 32'h7FFFFFFF, 32'h300,      32'h8,        1'b0, 1'b0, 32'h301,      1'b0};
      tbl[3]  = '{3'd0, 32'h1234,     32'h1234,     32'hFFFFFFFE, 32'h3,        1'b1, 1'b1, 32'h2,        1'b0};
      tbl[4]  = '{3'd6, 32'h5,        32'h5,        32'h40,       32'h20,       1'b0, 1'b0, 32'h41,       1'b0};
      tbl[5]  = '{3'd7, 32'h0,        32'h1,        32'h50,       32'h20,       1'b0, 1'b0, 32'h51,       1'b0};
      tbl[6]  = '{3'd5, 32'hFFFFFFFF, 32'h1,        32'h10,       32'h10,       1'b1, 1'b1, 32'h21,       1'b0};
      tbl[7]  = '{3'd1, 32'h3,        32'h3,        32'h60,       32'h4,        1'b0, 1'b0, 32'h61,       1'b0};
      tbl[8]  = '{3'd4, 32'h1,        32'hFFFFFFFF, 32'h70,       32'h2,        1'b1, 1'b1, 32'h73,       1'b0};
      tbl[9]  = '{3'd3, 32'h7,        32'h7,        32'h80,       32'h100,      1'b1, 1'b1, 32'h181,      1'b0};
      tbl[10] = '{3'd4, 32'hFFFFFFFF, 32'h1,        32'h500,      32'h40,       1'b1, 1'b0, 32'h501,      1'b1};

      // Reset state
      tick();
      tick();
      chk("rst_out_valid",  out_valid,  1'b0);
      chk("rst_target",     target,     32'h0);
      chk("rst_flush",      flush,      1'b0);
      chk("rst_in_ready",   in_ready,   1'b0);
      chk("rst8_out_valid", b_out_valid, 1'b0);
      chk("rst8_in_ready",  b_ready,    1'b0);
      reset = 0;
      #1;
      chk("ready_after_rst",  in_ready, 1'b1);
      chk("ready8_after_rst", b_ready,  1'b1);

      // Vector table, applied back-to-back
      for (int i = 0; i < 11; i++) begin
         op = tbl[i].op; in_A = tbl[i].a; in_B = tbl[i].b;
         pc = tbl[i].pc; offset = tbl[i].off; pred_taken = tbl[i].pred;
         in_valid = 1;
         tick();
         chk($sformatf("vec%0d_valid", i),  out_valid,  1'b1);
         chk($sformatf("vec%0d_taken", i),  taken,      tbl[i].e_taken);
         chk($sformatf("vec%0d_target", i), target,     tbl[i].e_target);
         chk($sformatf("vec%0d_mis", i),    mispredict, tbl[i].e_mis);
         if (tbl[i].e_mis) begin
            in_valid = 0;
            for (int k = 0; k < 8 && !in_ready; k++) tick();
            chk("vec_flush_exit", in_ready, 1'b1);
         end
      end
      in_valid = 0;
      tick();

      // Mispredict: two flush cycles, input dropped during them
      op = 3'd4; in_A = 32'hFFFFFFFF; in_B = 32'h1; pc = 32'h900; offset = 32'h40; pred_taken = 1;
      in_valid = 1;
      tick();
      chk("mp_mis",    mispredict, 1'b1);
      chk("mp_target", target,     32'h901);
      chk("mp_flush1", flush,      1'b1);
      chk("mp_ready1", in_ready,   1'b0);
      op = 3'd0; in_A = 32'h9; in_B = 32'h9; pred_taken = 0;
      tick();
      chk("mp_dropped", out_valid, 1'b0);
      chk("mp_flush2",  flush,     1'b1);
      chk("mp_ready2",  in_ready,  1'b0);
      in_valid = 0;
      tick();
      chk("mp_flush_end", flush,    1'b0);
      chk("mp_ready_end", in_ready, 1'b1);

      // Reset in the second flush cycle
      op = 3'd1; in_A = 32'h4; in_B = 32'h4; pred_taken = 1; in_valid = 1;
      tick();
      in_valid = 0;
      tick();
      chk("rf_flush2", flush, 1'b1);
      reset = 1;
      tick();
      chk("rf_flush_cleared", flush,     1'b0);
      chk("rf_valid_cleared", out_valid, 1'b0);
      reset = 0;
      #1;
      chk("rf_ready", in_ready, 1'b1);
`ifdef BRANCH_RESOLVE_STATS_EN
      chk("rf_stat_br",  stat_branches,    32'd0);
      chk("rf_stat_mis", stat_mispredicts, 32'd0);
`endif
      tick();

      // 8-bit instance, single flush cycle
      b_op = 3'd1; b_A = 8'h10; b_B = 8'h10; b_pc = 16'h20; b_off = 16'h5; b_pred = 1;
      b_valid = 1;
      tick();
      chk("w8_valid",  b_out_valid, 1'b1);
      chk("w8_taken",  b_taken,     1'b0);
      chk("w8_mis",    b_mis,       1'b1);
      chk("w8_target", b_target,    16'h21);
      chk("w8_flush",  b_flush,     1'b1);
      chk("w8_ready",  b_ready,     1'b0);
      b_valid = 0;
      tick();
      chk("w8_flush_end", b_flush,     1'b0);
      chk("w8_ready_end", b_ready,     1'b1);
      chk("w8_idle",      b_out_valid, 1'b0);
      b_op = 3'd0; b_valid = 1;
      tick();
      chk("w8_next_valid",  b_out_valid, 1'b1);
      chk("w8_next_taken",  b_taken,     1'b1);
      chk("w8_next_mis",    b_mis,       1'b0);
      chk("w8_next_target", b_target,    16'h26);
      b_op = 3'd2; b_A = 8'h80; b_B = 8'h7F; b_pc = 16'hFFFF; b_off = 16'h1;
      tick();
      chk("w8_slt_taken",  b_taken,  1'b1);
      chk("w8_slt_target", b_target, 16'h1);
      chk("w8_slt_flush",  b_flush,  1'b0);
      b_valid = 0;
      tick();

      // Randomised traffic against the model
      for (int n = 0; n < 600; n++) begin
         logic [31:0] edges[5];
         edges[0] = 32'h0; edges[1] = 32'h1; edges[2] = 32'h7FFFFFFF;
         edges[3] = 32'h80000000; edges[4] = 32'hFFFFFFFF;
         reset    = ($urandom_range(0, 99) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         op       = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 2))
            0: begin in_A = $urandom; in_B = $urandom; end
            1: begin in_A = $urandom; in_B = in_A; end
            default: begin
               in_A = edges[$urandom_range(0, 4)];
               in_B = edges[$urandom_range(0, 4)];
            end
         endcase
         pc     = $urandom;
         offset = $urandom;
         pred_taken = ($urandom_range(0, 4) != 0) ? ref_taken(op, in_A, in_B)
                                                  : ~ref_taken(op, in_A, in_B);
         tick();
      end
      reset = 0; in_valid = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-cycle branch compare logic. Resolves conditional branches at any operand width and supports six compare modes, signed and unsigned.
- Registers the outcome, computes the redirect target and checks it against the front-end prediction.
- On a mispredict, drives a multi-cycle pipeline flush with back-pressure.
- Sits between the register-read stage and fetch redirect in the pipelined processor.

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- PC_WIDTH, 32, program counter and offset width.
- FLUSH_CYCLES, 2, cycles flush stays asserted after a mispredict (>=1).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  branch operands present this cycle.
- in_ready  output  1  unit accepts a branch; transfer occurs when in_valid & in_ready.
- op  input  3  000 BEQ, 001 BNE, 010 BLT, 011 BGE, 100 BLTU, 101 BGEU, 110/111 reserved.
- in_A  input  WIDTH  first operand.
- in_B  input  WIDTH  second operand.
- pc  input  PC_WIDTH  branch instruction address.
- offset  input  PC_WIDTH  signed branch offset.
- pred_taken  input  1  front-end prediction.
- out_valid  output  1  registered result valid (one-cycle pulse per branch).
- taken  output  1  resolved direction.
- target  output  PC_WIDTH  next PC: pc+1+offset if taken, else pc+1.
- mispredict  output  1  taken != pred_taken, qualified by out_valid.
- flush  output  1  squash younger instructions.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values: out_valid=0, taken=0, target=0, mispredict=0, flush=0, in_ready=0 while reset is high. in_ready=1 on the first cycle after reset deasserts. FSM enters IDLE.
- Compare:
  - eq = (in_A==in_B).
  - Unsigned lt = borrow of the (WIDTH+1)-bit subtraction in_A-in_B.
  - Signed lt: if the sign bits differ, lt = in_A[WIDTH-1]; otherwise lt = MSB of the difference. This is overflow-free at every width.
  - BGE = ~lt (signed). BGEU = ~lt (unsigned).
  - Reserved ops resolve not-taken and are never reported as an error.
- Target arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- Latency: exactly 1 cycle from accepted input to out_valid/taken/target/mispredict. Outputs hold their last values when out_valid=0. mispredict is forced to 0 whenever out_valid=0.
- FSM IDLE:
  - in_ready=1.
  - An accepted branch whose result mispredicts moves to FLUSH on the edge that registers the result.
  - flush=1 in the same cycle as out_valid&mispredict.
- FSM FLUSH:
  - in_ready=0; in_valid is ignored.
  - A down-counter loads FLUSH_CYCLES-1 on entry and decrements each cycle.
  - flush stays 1 for exactly FLUSH_CYCLES cycles in total, counting the mispredict cycle.
  - Returns to IDLE when the counter reaches 0.
  - With FLUSH_CYCLES=1, the FLUSH state lasts one cycle: flush is high only on the mispredict cycle, and in_ready is low on that same cycle.
- Back-to-back: correctly predicted branches may be accepted every cycle.
- Reset mid-FLUSH aborts the flush immediately (flush=0 on the next cycle) and clears the counter.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- When defined, adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Each increments by 1 per out_valid pulse, respectively per out_valid&mispredict pulse.
  - Both saturate at all-ones and reset to 0.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - op encodings (OP_BEQ..OP_BGEU);
  - FSM state type (ST_IDLE, ST_FLUSH);
  - a helper constant for reserved-op detection.
- Natural sub-module: branch_compare_core, parametrised by WIDTH. It is purely combinational: op, in_A, in_B -> cond. It is reusable by the ALU set-less-than path.

Test Plan:
- WIDTH=32: BLT in_A=0xFFFFFFFF (-1), in_B=1, pred_taken=1 -> next cycle out_valid=1, taken=1, mispredict=0, flush=0, in_ready stays 1.
- BLTU with the same operands, pred_taken=1 -> taken=0, mispredict=1, target=pc+1. flush high 2 cycles (FLUSH_CYCLES=2); in_ready=0 for those 2 cycles, and an in_valid pulse during them is dropped.
- Signed overflow: BLT in_A=0x80000000, in_B=0x7FFFFFFF -> taken=1. BGE with the same operands -> taken=0.
- Target wrap: BEQ equal operands, pc=0xFFFFFFFE, offset=3, taken -> target=0x00000002. Reserved op 110 -> taken=0.
- Reset asserted in the second flush cycle -> flush=0 and out_valid=0 next cycle. in_ready=1 the cycle after reset deasserts. Stats (when enabled) read 0.
- WIDTH=8, FLUSH_CYCLES=1: BNE 0x10 vs 0x10, pred_taken=1 -> mispredict=1, flush high exactly 1 cycle, in_ready low that cycle only. Next branch is accepted the following cycle.
